// File: rtl/pkt_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pkt_gen_pkg                                            |
// | Description : Shared state encoding and default widths for the      |
// |               packet generator stream block.                         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package pkt_gen_pkg;

    localparam int c_def_addr_w = 2;
    localparam int c_def_type_w = 2;
    localparam int c_def_data_w = 8;
    localparam int c_def_len_w  = 4;
    localparam int c_def_cnt_w  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pkt_out_reg                                            |
// | Description : Single valid/ready holding register stage.             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module pkt_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_free,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_free;

    assign w_free  = !r_valid || i_ready;
    assign o_free  = w_free;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Data is only rewritten on a load, so it holds steady while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load && w_free) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_gen_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pkt_gen_stream                                         |
// | Description : Builds {eop, payload, type, dest} words from a latched |
// |               descriptor and a payload beat stream.                  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module pkt_gen_stream
    import pkt_gen_pkg::*;
#(
    parameter int ADDR_W = c_def_addr_w,
    parameter int TYPE_W = c_def_type_w,
    parameter int DATA_W = c_def_data_w,
    parameter int LEN_W  = c_def_len_w,
    parameter int CNT_W  = c_def_cnt_w
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             start_ready,
    input  logic [ADDR_W-1:0]                dest_address,
    input  logic [TYPE_W-1:0]                packet_type,
    input  logic [LEN_W-1:0]                 len,
    input  logic                             pl_valid,
    output logic                             pl_ready,
    input  logic [DATA_W-1:0]                payload,
    output logic                             src_valid,
    input  logic                             dest_ready,
    output logic [1+DATA_W+TYPE_W+ADDR_W-1:0] packet,
    output logic                             complete,
    output logic [CNT_W-1:0]                 pkt_count
);

    localparam int c_pkt_w = 1 + DATA_W + TYPE_W + ADDR_W;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_dest;
    logic [TYPE_W-1:0]   r_type;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_beat;
    logic                r_complete;
    logic [CNT_W-1:0]    r_count;
    logic                w_free;
    logic                w_load;
    logic                w_eop;
    logic                w_drain_done;
    logic [c_pkt_w-1:0]  w_word;

    assign w_load       = pl_valid && pl_ready;
    assign w_eop        = (r_beat == r_len);
    assign w_word       = {w_eop, payload, r_type, r_dest};
    assign w_drain_done = (r_state == ST_DRAIN) && src_valid && dest_ready;
    assign complete     = r_complete;
    assign pkt_count    = r_count;

    always_comb begin
        w_state_next = r_state;
        start_ready  = 1'b0;
        pl_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                pl_ready = w_free;
                if (pl_valid && w_free && w_eop) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (src_valid && dest_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dest     <= '0;
            r_type     <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_complete <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_complete <= w_drain_done;
            if (start && start_ready) begin
                r_dest <= dest_address;
                r_type <= packet_type;
                r_len  <= len;
                r_beat <= '0;
            end else if (w_load) begin
                r_beat <= r_beat + 1'b1;
            end
            // Count saturates rather than wrapping.
            if (w_drain_done && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    pkt_out_reg #(
        .WIDTH (c_pkt_w)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_word),
        .o_free  (w_free),
        .o_valid (src_valid),
        .o_data  (packet),
        .i_ready (dest_ready)
    );

endmodule
`default_nettype wire
